// File: rtl/rtdf_feed_if.sv
// Control/status bundle between the feed sequencer, the word FIFO read side and the sample generator.
interface rtdf_feed_if;
    localparam int unsigned WORDS_W = 9;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned UCNT_W  = 16;
    localparam int unsigned WCNT_W  = 32;

    logic               start;
    logic               stop;
    logic [WORDS_W-1:0] words_available;
    logic               fifo_empty;
    logic               word_request;
    logic               fifo_read;
    logic               sample_enable;
    logic [STATE_W-1:0] state;
    logic               underrun;
    logic               timeout;
    logic [UCNT_W-1:0]  underrun_count;
    logic [WCNT_W-1:0]  word_count;

    modport master (
        output start, stop, words_available, fifo_empty, word_request,
        input  fifo_read, sample_enable, state, underrun, timeout, underrun_count, word_count
    );

    modport slave (
        input  start, stop, words_available, fifo_empty, word_request,
        output fifo_read, sample_enable, state, underrun, timeout, underrun_count, word_count
    );
endinterface

// File: rtl/rtdf_feed_controller.sv
// Playback sequencer: prefill gating, underrun pause/resume, timeout abort and feed health counters.
module rtdf_feed_controller #(
    parameter logic [8:0]  PREFILL_WORDS  = 9'd128,
    parameter logic [8:0]  RESUME_WORDS   = 9'd32,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input  logic       clk_sample,
    input  logic       reset,
    rtdf_feed_if.slave feed
);
    localparam int unsigned TIMER_W = 24;
    localparam int unsigned UCNT_W  = 16;
    localparam int unsigned WCNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFILL  = 2'd1,
        STREAM   = 2'd2,
        UNDERRUN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                timeout_q, timeout_d;
    logic                abort_latch_q, abort_latch_d;
    logic                underrun_q, underrun_d;
    logic [UCNT_W-1:0]   underrun_count_q, underrun_count_d;
    logic [WCNT_W-1:0]   word_count_q, word_count_d;

    logic read_c;
    logic level_ok_c;
    logic expired_c;

    // Show-ahead read: the word is consumed in the same cycle the strobe is high
    assign read_c     = (state_q == STREAM) && feed.word_request && !feed.fifo_empty && !feed.stop;
    assign level_ok_c = feed.words_available >= ((state_q == PREFILL) ? PREFILL_WORDS : RESUME_WORDS);
    assign expired_c  = (timer_q == TIMEOUT_CYCLES - TIMER_W'(1));

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        timeout_d        = timeout_q;
        abort_latch_d    = abort_latch_q && feed.start;
        underrun_d       = 1'b0;
        underrun_count_d = underrun_count_q;
        word_count_d     = read_c ? word_count_q + WCNT_W'(1) : word_count_q;

        unique case (state_q)
            IDLE: begin
                if (feed.start && !feed.stop && !abort_latch_q) begin
                    state_d          = PREFILL;
                    timer_d          = '0;
                    timeout_d        = 1'b0;
                    underrun_count_d = '0;
                    word_count_d     = '0;
                end
            end
            PREFILL, UNDERRUN: begin
                if (feed.stop) begin
                    state_d = IDLE;
                end else if (level_ok_c) begin
                    state_d = STREAM;
                end else if (expired_c) begin
                    // start must drop once before a timed-out feed may restart
                    state_d       = IDLE;
                    timeout_d     = 1'b1;
                    abort_latch_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            STREAM: begin
                if (feed.stop) begin
                    state_d = IDLE;
                end else if (feed.word_request && feed.fifo_empty) begin
                    state_d    = UNDERRUN;
                    timer_d    = '0;
                    underrun_d = 1'b1;
                    if (underrun_count_q != {UCNT_W{1'b1}}) begin
                        underrun_count_d = underrun_count_q + UCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sample) begin
        if (reset) begin
            state_q          <= IDLE;
            timer_q          <= '0;
            timeout_q        <= 1'b0;
            abort_latch_q    <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= '0;
            word_count_q     <= '0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            timeout_q        <= timeout_d;
            abort_latch_q    <= abort_latch_d;
            underrun_q       <= underrun_d;
            underrun_count_q <= underrun_count_d;
            word_count_q     <= word_count_d;
        end
    end

    assign feed.fifo_read      = read_c;
    assign feed.sample_enable  = (state_q == STREAM);
    assign feed.state          = state_q;
    assign feed.underrun       = underrun_q;
    assign feed.timeout        = timeout_q;
    assign feed.underrun_count = underrun_count_q;
    assign feed.word_count     = word_count_q;
endmodule

// File: tb/tb_rtdf_feed_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural feed model.
module tb_rtdf_feed_controller;
    localparam int TB_PRE = 128;
    localparam int TB_RES = 32;
    localparam int TB_TMO = 100;

    logic clk;
    logic rst;
    rtdf_feed_if bus();

    rtdf_feed_controller #(
        .PREFILL_WORDS (9'd128),
        .RESUME_WORDS  (9'd32),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk_sample(clk),
        .reset     (rst),
        .feed      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 filling, 2 playing, 3 refilling after a starved request
    int       m_state;
    int       m_waited;
    bit       m_to;
    bit       m_blocked;
    bit       m_pulse;
    int       m_ucnt;
    bit [31:0] m_wcnt;

    function automatic bit exp_read();
        return (m_state == 2) && bus.word_request && !bus.fifo_empty && !bus.stop;
    endfunction

    task automatic model_step();
        int need;
        if (rst) begin
            m_state = 0; m_waited = 0; m_to = 0; m_blocked = 0;
            m_pulse = 0; m_ucnt = 0; m_wcnt = 0;
            return;
        end
        if (exp_read()) m_wcnt = m_wcnt + 1;
        m_pulse = 0;
        if (!bus.start) m_blocked = 0;
        if (m_state == 0) begin
            if (bus.start && !bus.stop && !m_blocked) begin
                m_state = 1; m_waited = 0; m_to = 0; m_ucnt = 0; m_wcnt = 0;
            end
        end else if (bus.stop) begin
            m_state = 0;
        end else if (m_state == 2) begin
            if (bus.word_request && bus.fifo_empty) begin
                m_state = 3; m_waited = 0; m_pulse = 1;
                if (m_ucnt < 65535) m_ucnt = m_ucnt + 1;
            end
        end else begin
            need = (m_state == 1) ? TB_PRE : TB_RES;
            if (int'(bus.words_available) >= need) begin
                m_state = 2;
            end else if (m_waited + 1 >= TB_TMO) begin
                m_state = 0; m_to = 1; m_blocked = 1;
            end else begin
                m_waited = m_waited + 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 32'(bus.state), 32'(m_state));
        chk("fifo_read", 32'(bus.fifo_read), 32'(exp_read()));
        chk("sample_enable", 32'(bus.sample_enable), 32'(m_state == 2));
        chk("underrun", 32'(bus.underrun), 32'(m_pulse));
        chk("timeout", 32'(bus.timeout), 32'(m_to));
        chk("underrun_count", 32'(bus.underrun_count), 32'(m_ucnt));
        chk("word_count", bus.word_count, m_wcnt);
    endtask

    task automatic pin(input string nm, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] lit);
        chk({nm, "_dut"}, dut_v, lit);
        chk({nm, "_model"}, mdl_v, lit);
    endtask

    task automatic cyc(input bit r, input bit s, input bit p, input int w, input bit e, input bit q);
        @(negedge clk);
        rst = r; bus.start = s; bus.stop = p;
        bus.words_available = 9'(w); bus.fifo_empty = e; bus.word_request = q;
        #1 check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic preload(input logic [15:0] u, input logic [31:0] wc);
        @(negedge clk);
        rst = 1'b0; bus.stop = 1'b0; bus.word_request = 1'b0; bus.fifo_empty = 1'b0;
        force dut.underrun_count_q = u;
        force dut.word_count_q = wc;
        m_ucnt = int'(u);
        m_wcnt = wc;
        #1 check_all();
        @(posedge clk);
        model_step();
        #1;
        release dut.underrun_count_q;
        release dut.word_count_q;
    endtask

    initial begin
        int regime;
        int w;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.words_available = '0;
        bus.fifo_empty = 1'b0; bus.word_request = 1'b0;
        repeat (2) @(posedge clk);
        model_step();
        #1;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        pin("rst_state", 32'(bus.state), 32'(m_state), 0);
        pin("rst_wcnt", bus.word_count, m_wcnt, 0);
        pin("rst_timeout", 32'(bus.timeout), 32'(m_to), 0);

        // Prefill gating
        cyc(0, 1, 0, 100, 0, 0);
        pin("prefill_enter", 32'(bus.state), 32'(m_state), 1);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 100, 0, 1);
        pin("prefill_hold", 32'(bus.state), 32'(m_state), 1);
        cyc(0, 1, 0, 128, 0, 1);
        pin("stream_enter", 32'(bus.state), 32'(m_state), 2);

        // Stream and count
        for (int i = 0; i < 50; i++) cyc(0, 0, 0, 128, 0, 1);
        pin("wcnt_50", bus.word_count, m_wcnt, 50);
        pin("ucnt_0", 32'(bus.underrun_count), 32'(m_ucnt), 0);

        // Underrun and resume
        cyc(0, 0, 0, 10, 1, 1);
        pin("underrun_state", 32'(bus.state), 32'(m_state), 3);
        pin("underrun_pulse", 32'(bus.underrun), 32'(m_pulse), 1);
        pin("underrun_cnt1", 32'(bus.underrun_count), 32'(m_ucnt), 1);
        pin("underrun_sen", 32'(bus.sample_enable), 32'(m_state == 2), 0);
        cyc(0, 0, 0, 10, 0, 0);
        pin("underrun_pulse_end", 32'(bus.underrun), 32'(m_pulse), 0);
        cyc(0, 0, 0, 32, 0, 0);
        pin("resume_state", 32'(bus.state), 32'(m_state), 2);

        // Stop beats a pending read
        cyc(0, 0, 1, 32, 0, 1);
        pin("stop_state", 32'(bus.state), 32'(m_state), 0);
        pin("stop_noread", bus.word_count, m_wcnt, 50);

        // Timeout abort and start-drop latch
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 99; i++) cyc(0, 1, 0, 0, 0, 0);
        pin("tmo_last_prefill", 32'(bus.state), 32'(m_state), 1);
        cyc(0, 1, 0, 0, 0, 0);
        pin("tmo_state", 32'(bus.state), 32'(m_state), 0);
        pin("tmo_flag", 32'(bus.timeout), 32'(m_to), 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
        pin("tmo_held_start", 32'(bus.state), 32'(m_state), 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        pin("tmo_restart", 32'(bus.state), 32'(m_state), 1);
        pin("tmo_cleared", 32'(bus.timeout), 32'(m_to), 0);

        // Saturation and wrap from preloaded counters
        cyc(0, 0, 0, 200, 0, 0);
        preload(16'hFFFE, 32'hFFFF_FFFE);
        cyc(0, 0, 0, 200, 1, 1);
        pin("sat_reach", 32'(bus.underrun_count), 32'(m_ucnt), 32'hFFFF);
        cyc(0, 0, 0, 200, 0, 0);
        cyc(0, 0, 0, 200, 1, 1);
        pin("sat_hold", 32'(bus.underrun_count), 32'(m_ucnt), 32'hFFFF);
        cyc(0, 0, 0, 200, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 200, 0, 1);
        pin("wcnt_wrap", bus.word_count, m_wcnt, 1);

        // Reset mid-stream
        cyc(1, 0, 0, 200, 0, 1);
        pin("midrst_state", 32'(bus.state), 32'(m_state), 0);
        pin("midrst_wcnt", bus.word_count, m_wcnt, 0);
        pin("midrst_ucnt", 32'(bus.underrun_count), 32'(m_ucnt), 0);

        // Randomized traffic with level regimes around the thresholds
        regime = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) regime = int'($urandom_range(0, 2));
            if (regime == 0)      w = int'($urandom_range(0, 40));
            else if (regime == 1) w = int'($urandom_range(100, 160));
            else                  w = int'($urandom_range(0, 511));
            cyc($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0,
                w, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rtdf_feed_controller.md
# rtdf_feed_controller

Playback sequencer for the real-time data feed sample path, in the `clk_sample` domain. Sits between the packet processor's word FIFO read side and the sample generator. It gates FIFO word reads and sample output so playback starts only after a prefill margin is buffered. It detects underruns, pauses until a resume margin refills, and reports feed health counters for debug.

## Interface
Parameters:
- PREFILL_WORDS, 9'd128, words_available level required to leave PREFILL.
- RESUME_WORDS, 9'd32, words_available level required to leave UNDERRUN.
- TIMEOUT_CYCLES, 24'd5000000, maximum cycles spent in PREFILL or UNDERRUN before abort.

Ports:
- clk_sample  in  1  sample clock; the only clock.
- reset  in  1  synchronous, active-high; priority over all inputs.
- start  in  1  level; request playback (acted on only in IDLE).
- stop  in  1  level; abort playback, return to IDLE.
- words_available  in  9  packet processor words ready to read.
- fifo_empty  in  1  packet processor empty flag.
- word_request  in  1  sample generator needs a word this cycle (fewer than 2 samples buffered).
- fifo_read  out  1  read strobe to the packet processor (combinational).
- sample_enable  out  1  sample generator may shift/output samples.
- state  out  2  0 IDLE, 1 PREFILL, 2 STREAM, 3 UNDERRUN.
- underrun  out  1  one-cycle pulse on each underrun.
- timeout  out  1  sticky abort flag.
- underrun_count  out  16  saturating underrun counter.
- word_count  out  32  words read since last start, wrapping.

## Operation
- IDLE: fifo_read=0, sample_enable=0. start && !stop -> PREFILL; clears timeout, underrun_count, word_count, and the timer.
- PREFILL: words_available >= PREFILL_WORDS -> STREAM. Otherwise the timer increments; timer == TIMEOUT_CYCLES-1 -> IDLE with timeout set.
- STREAM: sample_enable=1. fifo_read = word_request && !fifo_empty && !stop. word_request && fifo_empty -> UNDERRUN, underrun pulse, underrun_count+1 (holds at 16'hFFFF).
- UNDERRUN: sample_enable=0, fifo_read=0; words_available >= RESUME_WORDS -> STREAM. Otherwise timer behaviour is identical to PREFILL.
- Timer is 24 bits, zeroed on every entry to PREFILL/UNDERRUN. Threshold met in the same cycle as timer expiry: threshold wins, no timeout.
- stop in any non-IDLE state -> IDLE next cycle, no read issued that cycle. Priority: reset > stop > threshold > timeout > underrun.
- start held while not IDLE is ignored. start still high on return to IDLE restarts playback, except after a timeout: start must drop for at least one cycle first (timeout-abort latch).
- word_count increments by 1 on every cycle fifo_read=1 and wraps 32'hFFFFFFFF -> 0.
- Thresholds are compared unsigned at 9 bits. PREFILL_WORDS = 0 gives immediate PREFILL -> STREAM.

## Timing
- Reset values: state=IDLE, fifo_read=0, sample_enable=0, underrun=0, timeout=0, underrun_count=0, word_count=0, timer=0.
- All state and counters are registered. Transitions take effect the cycle after the condition is sampled.
- sample_enable is decoded from the state register, with no added latency.
- fifo_read is combinational from state, word_request, fifo_empty and stop. Data is consumed by the sample generator in the same cycle, matching packet processor show-ahead.
- Underrun detected in cycle N: in cycle N+1, state=UNDERRUN, underrun=1 (cycle N+1 only), underrun_count updated.
- Minimum start-to-STREAM latency: 2 cycles (IDLE->PREFILL, PREFILL->STREAM).
- Reset mid-playback: all outputs return to reset values on the next edge.

## Test plan
- Prefill: start=1 with words_available=100, then 128 at cycle 10 -> state PREFILL until cycle 11, then STREAM. fifo_read stays 0 before STREAM.
- Stream and count: in STREAM, word_request on 50 cycles with fifo_empty=0 -> 50 fifo_read strobes, word_count=50, underrun_count=0.
- Underrun and resume: fifo_empty=1 with word_request=1 -> next cycle underrun pulses once, count=1, sample_enable=0. words_available=32 -> STREAM one cycle later.
- Timeout: TIMEOUT_CYCLES=100, words_available held at 0 -> IDLE after 100 PREFILL cycles, timeout=1. Holding start does not restart; dropping and reasserting start clears timeout and enters PREFILL.
- Priority and saturation: stop asserted the same cycle as word_request with data available -> no fifo_read, IDLE next cycle. Preload 65535 underruns -> count stays 16'hFFFF on the next underrun.
- Reset mid-STREAM: reset pulse -> every output at its reset value next cycle, word_count=0.
